fifo_wptr_ctrl: RTL and testbench
=================================

// Module: fifo_wptr_ctrl
// PURPOSE
//  Write-side pointer controller for an async FIFO.
//  - Keeps a binary write pointer, converts it to Gray and registers it for the read domain.
//  - Generates full/almost-full and the fill level from the read pointer, which arrives in Gray code.
//  - Provides a drain (flush) handshake.
//  - Sits between the write client and the FIFO RAM write port.
// PARAMETERS
//  ADDR_WIDTH      4                    RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  ALMOST_FULL_TH  (1<<ADDR_WIDTH)-2    level at or above which almost_full_o asserts
// PORTS
//  clk_i          in   1             write-domain clock
//  rst_n_i        in   1             reset, synchronous, active-low
//  wr_valid_i     in   1             client has a word to write
//  wr_ready_o     out  1             controller accepts a write this cycle
//  flush_i        in   1             request to drain: stop accepting until the FIFO is empty
//  flush_done_o   out  1             1-cycle pulse when the drain completes
//  rd_ptr_gray_i  in   ADDR_WIDTH+1  read pointer in Gray code, already synchronised to clk_i
//  wr_en_o        out  1             RAM write strobe (= accepted write)
//  wr_addr_o      out  ADDR_WIDTH    RAM write address
//  wr_ptr_gray_o  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain
//  full_o         out  1             FIFO full (registered)
//  almost_full_o  out  1             level >= ALMOST_FULL_TH (registered)
//  wr_level_o     out  ADDR_WIDTH+1  fill level 0..2**ADDR_WIDTH (registered)
// BEHAVIOUR
//  Reset (rst_n_i=0 at a clk_i edge):
//  - binary ptr, wr_ptr_gray_o, full_o, almost_full_o, wr_level_o and flush_done_o all clear to 0.
//  - State goes to RUN.
//  - wr_ready_o and wr_en_o are forced to 0 combinationally while rst_n_i=0.
//  Handshake:
//  - wr_ready_o = rst_n_i & (state==RUN) & ~full_o & ~flush_i.
//  - accept = wr_valid_i & wr_ready_o; wr_en_o = accept (combinational).
//  - wr_addr_o = wr_ptr_bin[ADDR_WIDTH-1:0] (current registered pointer).
//  Pointer:
//  - On accept, wr_ptr_bin <= wr_ptr_bin+1, modulo 2**(ADDR_WIDTH+1). It wraps from all-ones to 0.
//  - wr_ptr_gray_o <= next_bin ^ (next_bin>>1), updated on the same edge.
//  - Exactly one bit of wr_ptr_gray_o changes per accept, including at wrap. The value never changes without an accept.
//  Full:
//  - full_o <= (next_gray == {~rd_g[AW:AW-1], rd_g[AW-2:0]}).
//  - next_gray is the Gray pointer after this cycle's accept; rd_g is rd_ptr_gray_i sampled this cycle.
//  - Valid for ADDR_WIDTH>=2.
//  - Full is pessimistic because the read pointer lags. It clears on the edge after the read pointer advances.
//  Level:
//  - rd_bin = Gray-to-binary(rd_ptr_gray_i).
//  - wr_level_o <= next_bin - rd_bin, modulo 2**(ADDR_WIDTH+1). 1-cycle latency.
//  - almost_full_o <= (that level >= ALMOST_FULL_TH).
//  Simultaneous accept and read-pointer advance: both take effect in the same next-state computation; no priority.
//  Flush FSM:
//  - RUN: flush_i=1 -> DRAIN. No write is accepted in the cycle flush_i is high.
//  - DRAIN: wr_ready_o=0. When rd_ptr_gray_i==wr_ptr_gray_o -> DONE.
//  - DONE: flush_done_o=1 (registered state decode), then -> RUN unconditionally.
//  - flush_i is ignored in DRAIN and DONE.
//  - Flushing an already-empty FIFO goes RUN->DRAIN->DONE->RUN; the done pulse comes 2 cycles after flush_i.
//  Reset mid-operation: the FIFO is abandoned and everything returns to the reset values above.
//  The read side must be reset together with this block.
// TESTING (ADDR_WIDTH=4, depth 16)
//  1. rst_n_i=0 for 3 cycles with wr_valid_i=1 -> wr_en_o=0, wr_ready_o=0 and all outputs 0 throughout.
//  2. Fill: rd_ptr_gray_i=0, wr_valid_i=1 continuously.
//     -> wr_addr_o steps 0..15 and 16 writes are accepted.
//     -> full_o=1 on the edge of the 16th accept; wr_ptr_gray_o=5'b11000 and wr_level_o=16.
//     -> 17th write refused; almost_full_o=1 once level reaches 14.
//  3. Then step rd_ptr_gray_i to gray(1)=5'b00001 -> full_o=0 next cycle and one more write is accepted.
//     Continue writing and reading to 40 writes total.
//     -> Binary pointer wraps 31->0; wr_ptr_gray_o goes 5'b10000 -> 5'b00000.
//  4. Random valid/read-pointer traffic, 200 writes:
//     -> Every wr_ptr_gray_o change differs from the previous value in exactly one bit.
//     -> wr_level_o always equals the model level; no write is accepted while full_o=1.
//  5. Flush: 5 writes, then flush_i=1 for 1 cycle alongside wr_valid_i=1.
//     -> The write is refused and wr_ready_o stays 0.
//     -> Set rd_ptr_gray_i=5'b00111 (gray 5): the edge after equality enters DONE; flush_done_o=1 for exactly 1 cycle, then wr_ready_o=1.
//  6. Reset mid-DRAIN with level 9 -> next cycle state RUN, pointers 0, flush_done_o never pulses.

Source files
------------

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for an async FIFO: binary/Gray write pointer,
// full/almost-full and fill level derived from the synchronised Gray read pointer, and a drain handshake.
module fifo_wptr_ctrl #(
   parameter int ADDR_WIDTH     = 4,
   parameter int ALMOST_FULL_TH = (1 << ADDR_WIDTH) - 2
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic                  flush_i,
   output logic                  flush_done_o,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray_i,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic [ADDR_WIDTH:0]   wr_level_o
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t          state;
   logic [PW-1:0]   wr_ptr_bin;
   logic [PW-1:0]   next_bin;
   logic [PW-1:0]   next_gray;
   logic [PW-1:0]   rd_bin;
   logic [PW-1:0]   level_next;
   logic [PW-1:0]   full_gray;
   logic            accept;

   assign wr_ready_o = rst_n_i & (state == RUN) & ~full_o & ~flush_i;
   assign accept     = wr_valid_i & wr_ready_o;
   assign wr_en_o    = accept;
   assign wr_addr_o  = wr_ptr_bin[ADDR_WIDTH-1:0];

   assign next_bin   = wr_ptr_bin + {{(PW-1){1'b0}}, accept};
   assign next_gray  = next_bin ^ (next_bin >> 1);

   // Full when the write pointer is exactly one lap ahead of the read pointer:
   // in Gray code that is the read pointer with its two top bits inverted.
   assign full_gray  = {~rd_ptr_gray_i[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr_gray_i[ADDR_WIDTH-2:0]};

   always_comb begin
      rd_bin = '0;
      for (int i = 0; i < PW; i++) begin
         rd_bin[i] = ^(rd_ptr_gray_i >> i);
      end
   end

   assign level_next = next_bin - rd_bin;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_bin    <= '0;
         wr_ptr_gray_o <= '0;
         full_o        <= 1'b0;
         almost_full_o <= 1'b0;
         wr_level_o    <= '0;
         flush_done_o  <= 1'b0;
         state         <= RUN;
      end else begin
         wr_ptr_bin    <= next_bin;
         wr_ptr_gray_o <= next_gray;
         full_o        <= (next_gray == full_gray);
         almost_full_o <= (level_next >= AF_TH);
         wr_level_o    <= level_next;
         flush_done_o  <= 1'b0;
         // Drain completes once the read side has caught up with everything written so far.
         case (state)
            RUN: begin
               if (flush_i) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (rd_ptr_gray_i == wr_ptr_gray_o) begin
                  state        <= DONE;
                  flush_done_o <= 1'b1;
               end
            end
            DONE: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl: table vectors for reset/fill/unfull,
// then model-checked wrap, random traffic, flush and reset-in-drain sequences.
module tb_fifo_wptr_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       wr_valid_i;
   logic       wr_ready_o;
   logic       flush_i;
   logic       flush_done_o;
   logic [4:0] rd_ptr_gray_i;
   logic       wr_en_o;
   logic [3:0] wr_addr_o;
   logic [4:0] wr_ptr_gray_o;
   logic       full_o;
   logic       almost_full_o;
   logic [4:0] wr_level_o;

   always #5 clk_i = ~clk_i;

   fifo_wptr_ctrl #(.ADDR_WIDTH(4), .ALMOST_FULL_TH(14)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .wr_valid_i    (wr_valid_i),
      .wr_ready_o    (wr_ready_o),
      .flush_i       (flush_i),
      .flush_done_o  (flush_done_o),
      .rd_ptr_gray_i (rd_ptr_gray_i),
      .wr_en_o       (wr_en_o),
      .wr_addr_o     (wr_addr_o),
      .wr_ptr_gray_o (wr_ptr_gray_o),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .wr_level_o    (wr_level_o)
   );

   typedef struct {
      logic       rst_n;
      logic       valid;
      logic       flush;
      logic [4:0] rd;
      logic       ready;
      logic       en;
      logic [3:0] addr;
      logic [4:0] gray;
      logic       full;
      logic       af;
      logic [4:0] level;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   logic [4:0] gtab [32] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4,
                             5'd12, 5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8,
                             5'd24, 5'd25, 5'd27, 5'd26, 5'd30, 5'd31, 5'd29, 5'd28,
                             5'd20, 5'd21, 5'd23, 5'd22, 5'd18, 5'd19, 5'd17, 5'd16};

   int tests = 0;
   int fails = 0;

   logic [4:0] m_ptr, m_gray, m_level;
   logic       m_full, m_af, m_done, m_acc;
   int         m_state;
   logic [4:0] prev_gray;
   bit         gcheck = 0;

   function automatic logic [4:0] g2b(input logic [4:0] g);
      for (int i = 0; i < 32; i++) begin
         if (gtab[i] == g) return i[4:0];
      end
      return 5'd0;
   endfunction

   function automatic vec_t mk(input logic r, input logic v, input logic f, input logic [4:0] rd,
                               input logic rdy, input logic en, input logic [3:0] addr,
                               input logic [4:0] gray, input logic full, input logic af,
                               input logic [4:0] lvl, input logic done);
      vec_t x;
      x.rst_n = r;   x.valid = v;  x.flush = f;   x.rd = rd;
      x.ready = rdy; x.en = en;    x.addr = addr; x.gray = gray;
      x.full = full; x.af = af;    x.level = lvl; x.done = done;
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic f, input logic [4:0] rd);
      rst_n_i       = r;
      wr_valid_i    = v;
      flush_i       = f;
      rd_ptr_gray_i = rd;
      #1;
   endtask

   task automatic checkModel();
      logic exp_ready;
      exp_ready = rst_n_i && (m_state == 0) && !m_full && !flush_i;
      checkOutput("ready", wr_ready_o, exp_ready);
      checkOutput("wr_en", wr_en_o, wr_valid_i & exp_ready);
      checkOutput("addr", wr_addr_o, m_ptr[3:0]);
      checkOutput("gray", wr_ptr_gray_o, m_gray);
      checkOutput("full", full_o, m_full);
      checkOutput("almost_full", almost_full_o, m_af);
      checkOutput("level", wr_level_o, m_level);
      checkOutput("flush_done", flush_done_o, m_done);
      checkOutput("no_write_when_full", full_o & wr_en_o, 0);
      if (gcheck) begin
         if (wr_ptr_gray_o !== prev_gray)
            checkOutput("gray_onebit", $countones(wr_ptr_gray_o ^ prev_gray), 1);
         prev_gray = wr_ptr_gray_o;
      end
   endtask

   task automatic tick();
      logic       rdy;
      logic [4:0] nptr, rdb, lvl;
      int         nstate;
      @(posedge clk_i);
      rdy   = rst_n_i && (m_state == 0) && !m_full && !flush_i;
      m_acc = wr_valid_i && rdy;
      if (!rst_n_i) begin
         m_ptr = 0; m_gray = 0; m_level = 0;
         m_full = 0; m_af = 0; m_done = 0; m_state = 0;
      end else begin
         nptr   = m_ptr + {4'b0, m_acc};
         rdb    = g2b(rd_ptr_gray_i);
         lvl    = nptr - rdb;
         nstate = m_state;
         case (m_state)
            0:       if (flush_i) nstate = 1;
            1:       if (rdb == m_ptr) nstate = 2;
            default: nstate = 0;
         endcase
         m_full  = (lvl == 5'd16);
         m_af    = (lvl >= 5'd14);
         m_level = lvl;
         m_gray  = gtab[nptr];
         m_done  = (nstate == 2);
         m_state = nstate;
         m_ptr   = nptr;
      end
      @(negedge clk_i);
   endtask

   task automatic cyc(input logic r, input logic v, input logic f, input logic [4:0] rd);
      applyStimulus(r, v, f, rd);
      checkModel();
      tick();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog timeout");
   end

   initial begin
      logic [4:0] rdb;
      int         writes;
      int         cnt;
      bit         seen_wrap;

      // Reset for 3 cycles with valid held high, then fill 16, then unfull by one read.
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 1, 0, 5'd0, 0, 0, 4'd0, 5'd0, 0, 0, 5'd0, 0));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(1, 1, 0, 5'd0, 1, 1, 4'(i), gtab[i], 0, (i >= 14), 5'(i), 0));
      vecs.push_back(mk(1, 1, 0, 5'd0, 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0));
      vecs.push_back(mk(1, 1, 0, 5'd1, 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0));
      vecs.push_back(mk(1, 1, 0, 5'd1, 1, 1, 4'd0, 5'b11000, 0, 1, 5'd15, 0));
      vecs.push_back(mk(1, 1, 0, 5'd1, 0, 0, 4'd1, 5'b11001, 1, 1, 5'd16, 0));

      @(negedge clk_i);
      applyStimulus(0, 1, 0, 5'd0);
      tick();

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].rst_n, vecs[k].valid, vecs[k].flush, vecs[k].rd);
         checkOutput($sformatf("vec%0d_ready", k), wr_ready_o, vecs[k].ready);
         checkOutput($sformatf("vec%0d_en", k), wr_en_o, vecs[k].en);
         checkOutput($sformatf("vec%0d_addr", k), wr_addr_o, vecs[k].addr);
         checkOutput($sformatf("vec%0d_gray", k), wr_ptr_gray_o, vecs[k].gray);
         checkOutput($sformatf("vec%0d_full", k), full_o, vecs[k].full);
         checkOutput($sformatf("vec%0d_af", k), almost_full_o, vecs[k].af);
         checkOutput($sformatf("vec%0d_level", k), wr_level_o, vecs[k].level);
         checkOutput($sformatf("vec%0d_done", k), flush_done_o, vecs[k].done);
         tick();
      end

      // Continue writing and reading to 40 writes, crossing the 31->0 wrap.
      rdb = 5'd1; writes = 17; cnt = 0; seen_wrap = 0;
      gcheck = 1; prev_gray = wr_ptr_gray_o;
      while (writes < 40 && cnt < 300) begin
         applyStimulus(1, 1, 0, gtab[rdb]);
         if (prev_gray == 5'b10000 && wr_ptr_gray_o == 5'b00000) seen_wrap = 1;
         checkModel();
         tick();
         if (m_acc) writes++;
         if (rdb != m_ptr) rdb++;
         cnt++;
      end
      applyStimulus(1, 0, 0, gtab[rdb]);
      checkOutput("wrap_write_count", writes, 40);
      checkOutput("wrap_seen", seen_wrap, 1);
      checkOutput("addr_after40", wr_addr_o, 4'd8);
      checkOutput("gray_after40", wr_ptr_gray_o, 5'b01100);
      checkModel();
      tick();

      // Random valid / read-pointer traffic.
      writes = 0; cnt = 0;
      while (writes < 200 && cnt < 4000) begin
         cyc(1, ($urandom_range(0, 3) != 0), 0, gtab[rdb]);
         if (m_acc) writes++;
         if (rdb != m_ptr && $urandom_range(0, 1) == 1) rdb++;
         cnt++;
      end
      checkOutput("random_write_count", writes, 200);
      gcheck = 0;

      // Flush after 5 writes.
      cyc(0, 0, 0, 5'd0);
      cyc(0, 0, 0, 5'd0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 5'd0);
      applyStimulus(1, 1, 1, 5'd0);
      checkOutput("flush_refused_en", wr_en_o, 0);
      checkOutput("flush_refused_ready", wr_ready_o, 0);
      checkModel();
      tick();
      applyStimulus(1, 1, 0, 5'd0);
      checkOutput("drain_ready", wr_ready_o, 0);
      checkOutput("drain_level", wr_level_o, 5'd5);
      checkModel();
      tick();
      applyStimulus(1, 1, 0, 5'b00111);
      checkOutput("drain_eq_done", flush_done_o, 0);
      checkOutput("drain_eq_ready", wr_ready_o, 0);
      checkModel();
      tick();
      applyStimulus(1, 1, 0, 5'b00111);
      checkOutput("done_pulse", flush_done_o, 1);
      checkOutput("done_ready", wr_ready_o, 0);
      checkModel();
      tick();
      applyStimulus(1, 0, 0, 5'b00111);
      checkOutput("after_done_pulse", flush_done_o, 0);
      checkOutput("after_done_ready", wr_ready_o, 1);
      checkOutput("after_done_level", wr_level_o, 5'd0);
      checkModel();
      tick();

      // Reset in the middle of a drain with level 9.
      cyc(0, 0, 0, 5'd0);
      cyc(0, 0, 0, 5'd0);
      for (int i = 0; i < 9; i++) cyc(1, 1, 0, 5'd0);
      cyc(1, 0, 1, 5'd0);
      applyStimulus(1, 0, 0, 5'd0);
      checkOutput("mid_drain_level", wr_level_o, 5'd9);
      checkOutput("mid_drain_ready", wr_ready_o, 0);
      checkModel();
      tick();
      applyStimulus(0, 1, 0, 5'd0);
      checkOutput("rst_drain_ready", wr_ready_o, 0);
      checkOutput("rst_drain_en", wr_en_o, 0);
      checkOutput("rst_drain_done", flush_done_o, 0);
      tick();
      applyStimulus(1, 0, 0, 5'd0);
      checkOutput("post_rst_gray", wr_ptr_gray_o, 5'd0);
      checkOutput("post_rst_addr", wr_addr_o, 4'd0);
      checkOutput("post_rst_level", wr_level_o, 5'd0);
      checkOutput("post_rst_full", full_o, 0);
      checkOutput("post_rst_ready", wr_ready_o, 1);
      checkOutput("post_rst_done", flush_done_o, 0);
      checkModel();
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 5'd0);
         checkOutput("post_rst_no_done", flush_done_o, 0);
         tick();
      end

      // Flush of an empty FIFO: done pulse two cycles after flush_i.
      cyc(1, 0, 1, 5'd0);
      applyStimulus(1, 0, 0, 5'd0);
      checkOutput("empty_flush_c1_done", flush_done_o, 0);
      checkModel();
      tick();
      applyStimulus(1, 0, 0, 5'd0);
      checkOutput("empty_flush_c2_done", flush_done_o, 1);
      checkModel();
      tick();
      applyStimulus(1, 0, 0, 5'd0);
      checkOutput("empty_flush_c3_done", flush_done_o, 0);
      checkOutput("empty_flush_c3_ready", wr_ready_o, 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
